// File: rtl/sub_flag_reg_pkg.sv
// Shared definitions for the subtractor/adder output stages.
//   - Flag bit positions within the 4-bit {N, Z, C, V} flag vector.
//   - Skid-buffer occupancy state encoding.
package sub_flag_reg_pkg;

  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  // Buffer occupancy: no entries, head only, head and tail.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } state_e;

endpackage

// File: rtl/sub_flag_gen.sv
// Combinational NZCV flag generator for an N-bit arithmetic result.
// Ports:
//   s_i        - result value
//   cout_i     - raw carry-out (not converted to a borrow)
//   overflow_i - signed overflow
//   flags_o    - {N, Z, C, V}
module sub_flag_gen
  import sub_flag_reg_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] s_i,
  input  logic         cout_i,
  input  logic         overflow_i,
  output logic [3:0]   flags_o
);

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_N] = s_i[N-1];
    flags_o[FLAG_Z] = (s_i == '0);
    flags_o[FLAG_C] = cout_i;
    flags_o[FLAG_V] = overflow_i;
  end

endmodule

// File: rtl/sub_flag_reg.sv
// Registered output stage for the N-bit subtractor: a two-entry skid buffer with
// valid/ready handshakes on both sides, NZCV flag capture and a saturating
// overflow event counter.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   in_valid/in_ready           - upstream handshake
//   in_s, in_cout, in_overflow  - subtractor result
//   out_valid/out_ready         - downstream handshake
//   out_s, out_flags            - head entry value and {N, Z, C, V}
//   ovf_count, clr_count        - saturating count of accepted V=1 results, clear
module sub_flag_reg
  import sub_flag_reg_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_s,
  input  logic          in_cout,
  input  logic          in_overflow,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_s,
  output logic [3:0]    out_flags,
  output logic [CW-1:0] ovf_count,
  input  logic          clr_count
);

  state_e        state_q, state_d;
  logic [N-1:0]  head_s_q, head_s_d, tail_s_q, tail_s_d;
  logic [3:0]    head_f_q, head_f_d, tail_f_q, tail_f_d;
  logic [CW-1:0] ovf_count_q, ovf_count_d;
  logic [3:0]    new_flags;
  logic          in_xfer, out_xfer;

  sub_flag_gen #(
    .N (N)
  ) u_flag_gen (
    .s_i        (in_s),
    .cout_i     (in_cout),
    .overflow_i (in_overflow),
    .flags_o    (new_flags)
  );

  // Both handshake outputs decode straight from the state register, so there
  // is no combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_s     = head_s_q;
  assign out_flags = head_f_q;
  assign ovf_count = ovf_count_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    head_s_d = head_s_q;
    head_f_d = head_f_q;
    tail_s_d = tail_s_q;
    tail_f_d = tail_f_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          head_s_d = in_s;
          head_f_d = new_flags;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (in_xfer && !out_xfer) begin
          tail_s_d = in_s;
          tail_f_d = new_flags;
          state_d  = StFull;
        end else if (out_xfer && !in_xfer) begin
          state_d = StEmpty;
        end else if (in_xfer && out_xfer) begin
          head_s_d = in_s;
          head_f_d = new_flags;
        end
      end
      StFull: begin
        if (out_xfer) begin
          head_s_d = tail_s_q;
          head_f_d = tail_f_q;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Clear wins over a coincident overflow event; counting stops at all-ones.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (clr_count) begin
      ovf_count_d = '0;
    end else if (in_xfer && new_flags[FLAG_V] && (ovf_count_q != {CW{1'b1}})) begin
      ovf_count_d = ovf_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_s_q    <= '0;
      head_f_q    <= '0;
      tail_s_q    <= '0;
      tail_f_q    <= '0;
      ovf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      head_s_q    <= head_s_d;
      head_f_q    <= head_f_d;
      tail_s_q    <= tail_s_d;
      tail_f_q    <= tail_f_d;
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_sub_flag_reg.sv
// Self-checking bench for sub_flag_reg: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_sub_flag_reg;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_cout, in_overflow;
  logic [N-1:0]  in_s;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_s;
  logic [3:0]    out_flags;
  logic [CW-1:0] ovf_count;
  logic          clr_count;

  always #5 clk = ~clk;

  sub_flag_reg #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_s        (in_s),
    .in_cout     (in_cout),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .out_flags   (out_flags),
    .ovf_count   (ovf_count),
    .clr_count   (clr_count)
  );

  typedef struct {
    logic [N-1:0] s;
    logic [3:0]   f;
  } ent_t;

  ent_t         mq[$];
  int           m_cnt;
  logic [N-1:0] m_disp_s;
  logic [3:0]   m_disp_f;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // {N, Z, C, V} straight from the arithmetic meaning of the result.
  function automatic logic [3:0] mk_flags(input logic [N-1:0] s, input logic c, input logic v);
    logic neg, zero;
    neg  = (int'(s) >= (1 << (N - 1)));
    zero = (int'(s) == 0);
    return {neg, zero, c, v};
  endfunction

  task automatic drive(input logic v, input logic [N-1:0] s, input logic c, input logic o,
                       input logic ordy, input logic clr);
    in_valid    = v;
    in_s        = s;
    in_cout     = c;
    in_overflow = o;
    out_ready   = ordy;
    clr_count   = clr;
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    logic in_x, out_x;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_cnt    = 0;
      m_disp_s = '0;
      m_disp_f = '0;
    end else begin
      in_x  = in_valid && (mq.size() < 2);
      out_x = out_ready && (mq.size() > 0);
      if (clr_count) m_cnt = 0;
      else if (in_x && in_overflow && m_cnt < (1 << CW) - 1) m_cnt++;
      if (out_x) void'(mq.pop_front());
      if (in_x) mq.push_back('{s: in_s, f: mk_flags(in_s, in_cout, in_overflow)});
      if (mq.size() > 0) begin
        m_disp_s = mq[0].s;
        m_disp_f = mq[0].f;
      end
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check_eq("out_s", 32'(out_s), 32'(m_disp_s));
    check_eq("out_flags", 32'(out_flags), 32'(m_disp_f));
    check_eq("ovf_count", 32'(ovf_count), 32'(m_cnt));
  endtask

  initial begin
    m_cnt = 0; m_disp_s = '0; m_disp_f = '0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset then a single result
    step(); step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("single_flags", 32'(out_flags), 32'b0110);
    check_eq("single_s", 32'(out_s), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // Back-pressure fill
    drive(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("fill_head_s", 32'(out_s), 32'b1001);
    check_eq("fill_head_f", 32'(out_flags), 32'b1001);
    check_eq("fill_ovf", 32'(ovf_count), 32'd1);

    // Drain order
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("drain_first", 32'(out_s), 32'b0111);
    check_eq("drain_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("drain_empty", 32'(out_valid), 32'd0);

    // Streaming 0..9
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, N'(i), 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      check_eq("stream_s", 32'(out_s), 32'(i));
      check_eq("stream_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // Counter saturation and clear
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, N'(i), 1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    check_eq("sat_count", 32'(ovf_count), 32'd255);
    drive(1'b1, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check_eq("clr_count", 32'(ovf_count), 32'd0);

    // Reset mid-operation from FULL
    drive(1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); step();
    check_eq("pre_rst_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_ovf", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("post_rst_alone", 32'(out_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 9) < 7), N'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sub_flag_reg.md
Name: sub_flag_reg

Overview:
- Registered output stage placed directly downstream of the combinational n-bit subtractor (sum, carry-out and overflow outputs).
- Captures each subtractor result with a valid/ready handshake and buffers up to two results in a skid buffer, so the subtractor never has to hold its operands for more than one accepted cycle.
- Derives the NZCV status flags for each result.
- Keeps a saturating count of overflow events for the lab status display.

Parameters:
- N, 4, data width; must match the subtractor width (N >= 2).
- CW, 8, width of the overflow event counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- in_valid  input  1  a subtractor result is presented
- in_ready  output  1  stage can accept a result this cycle
- in_s  input  N  difference from the subtractor
- in_cout  input  1  carry-out from the subtractor
- in_overflow  input  1  signed overflow from the subtractor
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer accepts the head entry this cycle
- out_s  output  N  head entry difference
- out_flags  output  4  head entry flags {N, Z, C, V}
- ovf_count  output  CW  saturating count of accepted results with V = 1
- clr_count  input  1  synchronous clear of ovf_count

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: state = EMPTY, out_valid = 0, in_ready = 1, out_s = 0, out_flags = 0, ovf_count = 0, both buffer entries = 0.
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Flag formation happens at capture, from the input signals:
  - Z = (in_s == 0)
  - N = in_s[N-1]
  - C = in_cout (raw carry of x + two's-complement(y); no inversion into a borrow)
  - V = in_overflow
- Storage: two entries, head (H) and tail (T), each holding s plus 4 flag bits.
- Outputs: out_s and out_flags always show H. They are don't-care when out_valid = 0 but must hold their last value.
- Latency: a result accepted at edge k appears on out_* with out_valid = 1 after edge k when the buffer was EMPTY (one-cycle latency). There is no combinational path from in_* to out_*.
- in_ready = (state != FULL). It is registered, with no combinational dependence on out_ready.
- State machine (one input transfer = in, one output transfer = out):
  - EMPTY:
    - in: H <= new; go to ONE.
    - otherwise: stay EMPTY.
  - ONE:
    - in and no out: T <= new; go to FULL.
    - out and no in: go to EMPTY.
    - in and out together: H <= new; stay ONE.
    - neither: hold.
  - FULL (in_ready = 0, so no input transfer is possible):
    - out: H <= T; go to ONE.
    - otherwise: hold.
- out_valid = (state != EMPTY).
- ovf_count, evaluated in priority order each edge:
  1. clr_count = 1: ovf_count <= 0. If an input transfer with V = 1 happens in the same cycle, it is not counted.
  2. Otherwise, on an input transfer with V = 1: ovf_count <= ovf_count + 1, saturating at 2^CW − 1 (no wrap-around).
- Reset mid-operation: asserting rst_n = 0 discards both entries at the next edge regardless of the handshake. The result presented in that cycle is not captured and not counted.
- Entry contents never change while held: no transfers means no changes.

Decomposition:
- Shared package/header holds:
  - flag bit indices: FLAG_V = 0, FLAG_C = 1, FLAG_Z = 2, FLAG_N = 3;
  - state encodings: EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10.
- One sub-module is natural: sub_flag_gen, a combinational block that takes (s, cout, overflow) and produces the 4 flags. It is reused later by the adder output stage.
- Skid-buffer control and the counter stay in sub_flag_reg.

Test Plan:
- Reset then single result (N = 4):
  - Stimulus: rst_n = 0 for 2 cycles, release; present in_s = 4'b0000, cout = 1, ovf = 0 for one accepted cycle.
  - Required: next cycle out_valid = 1, out_s = 0, out_flags = {0,1,1,0}; ovf_count = 0.
- Back-pressure fill:
  - Stimulus: out_ready = 0; present 4'b1001/V=1, then 4'b0111/V=0.
  - Required: after 2 edges in_ready = 0 and state FULL; a third offered result is not accepted; head = 4'b1001 with flags {1,0,x,1}; ovf_count = 1.
- Drain order:
  - Stimulus: from FULL, raise out_ready for 2 cycles.
  - Required: out_s = 4'b1001 then 4'b0111; out_valid falls after the second transfer; in_ready = 1 again after the first.
- Streaming:
  - Stimulus: in_valid and out_ready held at 1 for 10 cycles with values 0..9.
  - Required: state stays ONE; out_s shows 0..9 one cycle delayed; no value is lost or duplicated.
- Counter saturation and clear (CW = 8):
  - Stimulus: 300 accepted results with V = 1.
  - Required: ovf_count = 255 and held there.
  - Stimulus: then clr_count = 1 together with a V = 1 transfer.
  - Required: ovf_count = 0.
- Reset mid-operation:
  - Stimulus: FULL state, out_ready = 0, in_valid = 1; assert rst_n = 0 for one edge.
  - Required: out_valid = 0, in_ready = 1, ovf_count = 0; the next accepted result appears alone at the head.
